// File: rtl/pola_yolo_collect_pkg.sv
// rtl/pola_yolo_collect_pkg.sv - shared state encoding and record/trailer layout helpers for the detection collector
// Purpose: FSM state type, record width derivation and field offsets used by
//          pola_yolo_detect_collector. No ports.
package pola_yolo_collect_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_TRAILER = 2'd2,
    ST_CLEAR   = 2'd3
  } state_e;

  // Record is {x, y, w, h, class, conf}, MSB to LSB.
  function automatic int rec_w(input int data_bit, input int class_bit);
    return 5 * data_bit + class_bit;
  endfunction

  localparam int REC_CONF_LSB = 0;

  function automatic int rec_class_lsb(input int data_bit);
    return data_bit;
  endfunction

  function automatic int rec_h_lsb(input int data_bit, input int class_bit);
    return data_bit + class_bit;
  endfunction

  function automatic int rec_w_lsb(input int data_bit, input int class_bit);
    return 2 * data_bit + class_bit;
  endfunction

  function automatic int rec_y_lsb(input int data_bit, input int class_bit);
    return 3 * data_bit + class_bit;
  endfunction

  function automatic int rec_x_lsb(input int data_bit, input int class_bit);
    return 4 * data_bit + class_bit;
  endfunction

  // Trailer is {zeros, det_count, drop_cnt}.
  localparam int TRL_DROP_LSB = 0;

  function automatic int trl_count_lsb(input int cnt_bit);
    return cnt_bit;
  endfunction

endpackage

// File: rtl/pola_yolo_sync_fifo.sv
// rtl/pola_yolo_sync_fifo.sv - single-clock FIFO with full/empty flags and same-cycle read/write
// Purpose: record buffer for the detection collector.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  write request and data; accepted when not full or when a read happens in the same cycle
//   rd_en, rd_data  read request; rd_data is the current head (valid while !empty)
//   full, empty     occupancy flags
//   count           number of stored entries
module pola_yolo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_ok, rd_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    rd_ok    = rd_en && !empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok && !rd_ok) cnt_d = cnt_q + (AW+1)'(1);
    if (!wr_ok && rd_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pola_yolo_detect_collector.sv
// rtl/pola_yolo_detect_collector.sv - compacts gated YOLO detections into a record stream with a per-frame trailer
// Purpose: captures valid detections into a FIFO, drains them as ready/valid records
//          and closes each frame with a trailer {det_count, drop_cnt}, m_last=1.
// Optional: define POLA_YOLO_COLLECT_ZERO_SKIP_EN to ignore detections with det_conf==0.
// Ports:
//   M_AXI_ACLK, rst                 clock, synchronous active-high reset
//   det_valid, det_x/y/w/h,
//   det_class, det_conf             delayed gated detection input
//   frame_end                       single-cycle frame close pulse
//   m_valid, m_ready, m_data, m_last  record output stream
//   busy                            high outside COLLECT
//   det_count                       detections accepted this frame (saturating)
//   overflow                        sticky drop flag for this frame
module pola_yolo_detect_collector
  import pola_yolo_collect_pkg::*;
#(
  parameter int Data_bit   = 16,
  parameter int Class_bit  = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_bit    = 16,
  localparam int REC_W     = rec_w(Data_bit, Class_bit)
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 rst,
  input  logic                 det_valid,
  input  logic [Data_bit-1:0]  det_x,
  input  logic [Data_bit-1:0]  det_y,
  input  logic [Data_bit-1:0]  det_w,
  input  logic [Data_bit-1:0]  det_h,
  input  logic [Class_bit-1:0] det_class,
  input  logic [Data_bit-1:0]  det_conf,
  input  logic                 frame_end,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [REC_W-1:0]     m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic [CNT_bit-1:0]   det_count,
  output logic                 overflow
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int X_LSB   = rec_x_lsb(Data_bit, Class_bit);
  localparam int Y_LSB   = rec_y_lsb(Data_bit, Class_bit);
  localparam int W_LSB   = rec_w_lsb(Data_bit, Class_bit);
  localparam int H_LSB   = rec_h_lsb(Data_bit, Class_bit);
  localparam int C_LSB   = rec_class_lsb(Data_bit);
  localparam int CNT_LSB = trl_count_lsb(CNT_bit);

  state_e             state_q, state_d;
  logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic               busy_q, busy_d, ovf_q, ovf_d;
  logic [REC_W-1:0]   m_data_q, m_data_d, rec_in, trl, fifo_rdata;
  logic [CNT_bit-1:0] det_cnt_q, det_cnt_d, drop_cnt_q, drop_cnt_d;
  logic               fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic               det_qual, xfer, out_free, room, drop;
  logic [AW:0]        fifo_cnt;
  logic [AW+1:0]      occ;

  function automatic logic [CNT_bit-1:0] sat_inc(input logic [CNT_bit-1:0] v);
    return (&v) ? v : v + CNT_bit'(1);
  endfunction

`ifdef POLA_YOLO_COLLECT_ZERO_SKIP_EN
  assign det_qual = det_valid && (det_conf != '0);
`else
  assign det_qual = det_valid;
`endif

  pola_yolo_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (M_AXI_ACLK),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (rec_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    rec_in = '0;
    rec_in[X_LSB +: Data_bit]        = det_x;
    rec_in[Y_LSB +: Data_bit]        = det_y;
    rec_in[W_LSB +: Data_bit]        = det_w;
    rec_in[H_LSB +: Data_bit]        = det_h;
    rec_in[C_LSB +: Class_bit]       = det_class;
    rec_in[REC_CONF_LSB +: Data_bit] = det_conf;
  end

  always_comb begin
    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;
    det_cnt_d  = det_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    trl        = '0;

    xfer     = m_valid_q && m_ready;
    out_free = !m_valid_q || m_ready;
    fifo_rd  = !fifo_empty && out_free &&
               ((state_q == ST_COLLECT) || (state_q == ST_FLUSH));
    // The output register counts toward FIFO_DEPTH, so at most FIFO_DEPTH
    // records are held; an output transfer frees a slot in the same cycle.
    occ      = {1'b0, fifo_cnt} + {{(AW+1){1'b0}}, m_valid_q};
    room     = !fifo_full && (occ < (AW+2)'(FIFO_DEPTH));
    fifo_wr  = (state_q == ST_COLLECT) && det_qual && (room || xfer);
    drop     = det_qual && !fifo_wr;

    if (fifo_wr) det_cnt_d = sat_inc(det_cnt_q);
    if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
      ovf_d      = 1'b1;
    end

    if (xfer) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    if (fifo_rd) begin
      m_valid_d = 1'b1;
      m_last_d  = 1'b0;
      m_data_d  = fifo_rdata;
    end

    case (state_q)
      ST_COLLECT: if (frame_end) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (fifo_empty && out_free) begin
          // drop_cnt_d so a drop on this very cycle still lands in the trailer.
          trl[CNT_LSB +: CNT_bit]      = det_cnt_q;
          trl[TRL_DROP_LSB +: CNT_bit] = drop_cnt_d;
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          m_data_d  = trl;
          state_d   = ST_TRAILER;
        end
      end
      ST_TRAILER: if (xfer) state_d = ST_CLEAR;
      ST_CLEAR: begin
        det_cnt_d  = '0;
        drop_cnt_d = '0;
        ovf_d      = 1'b0;
        state_d    = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase

    busy_d = (state_d != ST_COLLECT);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (rst) begin
      state_q    <= ST_COLLECT;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      busy_q     <= 1'b0;
      det_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
      busy_q     <= busy_d;
      det_cnt_q  <= det_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_data    = m_data_q;
  assign busy      = busy_q;
  assign det_count = det_cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pola_yolo_detect_collector.sv
// tb/tb_pola_yolo_detect_collector.sv - directed self-checking bench for pola_yolo_detect_collector
module tb_pola_yolo_detect_collector;

  localparam int DB    = 16;
  localparam int CB    = 8;
  localparam int DEPTH = 4;
  localparam int CNTB  = 16;
  localparam int REC_W = 5 * DB + CB;

  logic              M_AXI_ACLK = 1'b0;
  logic              rst        = 1'b1;
  logic              det_valid  = 1'b0;
  logic [DB-1:0]     det_x = '0, det_y = '0, det_w = '0, det_h = '0, det_conf = '0;
  logic [CB-1:0]     det_class  = '0;
  logic              frame_end  = 1'b0;
  logic              m_ready    = 1'b1;
  logic              m_valid, m_last, busy, overflow;
  logic [REC_W-1:0]  m_data;
  logic [CNTB-1:0]   det_count;

  int checks = 0;
  int errors = 0;

  logic [REC_W-1:0] recs[$];
  logic [REC_W-1:0] trl_data;
  bit               trl_seen;
  int               stall_viol;

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  pola_yolo_detect_collector #(
    .Data_bit   (DB),
    .Class_bit  (CB),
    .FIFO_DEPTH (DEPTH),
    .CNT_bit    (CNTB)
  ) dut (
    .M_AXI_ACLK (M_AXI_ACLK),
    .rst        (rst),
    .det_valid  (det_valid),
    .det_x      (det_x),
    .det_y      (det_y),
    .det_w      (det_w),
    .det_h      (det_h),
    .det_class  (det_class),
    .det_conf   (det_conf),
    .frame_end  (frame_end),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .det_count  (det_count),
    .overflow   (overflow)
  );

  // Fixed box y=-3, w=10, h=20, class=2; x and conf vary per record.
  function automatic logic [REC_W-1:0] rec(input logic [15:0] x, input logic [15:0] conf);
    return {x, 16'hFFFD, 16'h000A, 16'h0014, 8'h02, conf};
  endfunction

  function automatic logic [REC_W-1:0] trl(input int c, input int d);
    logic [15:0] cc, dd;
    cc = c[15:0];
    dd = d[15:0];
    return {56'd0, cc, dd};
  endfunction

  task automatic step();
    @(posedge M_AXI_ACLK);
    #1;
  endtask

  task automatic set_det(input bit v, input logic [15:0] x, input logic [15:0] conf);
    det_valid = v;
    det_x     = x;
    det_y     = 16'hFFFD;
    det_w     = 16'd10;
    det_h     = 16'd20;
    det_class = 8'd2;
    det_conf  = conf;
  endtask

  // Collects records until the trailer transfers (bounded); tracks stall stability.
  task automatic drain(input int budget, input bit toggle);
    bit               stalled;
    logic [REC_W-1:0] hd;
    logic             hl;
    recs.delete();
    trl_seen   = 0;
    stall_viol = 0;
    stalled    = 0;
    hd         = '0;
    hl         = 1'b0;
    for (int i = 0; i < budget && !trl_seen; i++) begin
      if (stalled && (m_valid !== 1'b1 || m_data !== hd || m_last !== hl)) stall_viol++;
      m_ready = toggle ? (i % 2 == 1) : 1'b1;
      if (m_valid === 1'b1 && m_ready) begin
        if (m_last === 1'b1) begin
          trl_seen = 1;
          trl_data = m_data;
        end else begin
          recs.push_back(m_data);
        end
      end
      stalled = (m_valid === 1'b1) && !m_ready;
      hd = m_data;
      hl = m_last;
      step();
    end
    m_ready = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic close_frame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (det_count !== '0) begin errors++; $display("FAIL reset_det_count: got %0d want 0", det_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_capture();
    bit ok;
    m_ready = 1'b1;
    set_det(1, 16'd5, 16'd100);
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL cap_latency_early: got m_valid=%b want 0", m_valid); end
    set_det(1, 16'd6, 16'd100);
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== rec(16'd5, 16'd100)) begin errors++; $display("FAIL cap_rec0: got v=%b %h want v=1 %h", m_valid, m_data, rec(16'd5, 16'd100)); end
    set_det(1, 16'd7, 16'd100);
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== rec(16'd6, 16'd100)) begin errors++; $display("FAIL cap_rec1: got v=%b %h want v=1 %h", m_valid, m_data, rec(16'd6, 16'd100)); end
    set_det(0, 16'd0, 16'd0);
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== rec(16'd7, 16'd100) || m_last !== 1'b0) begin errors++; $display("FAIL cap_rec2: got v=%b l=%b %h want v=1 l=0 %h", m_valid, m_last, m_data, rec(16'd7, 16'd100)); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL cap_idle: got m_valid=%b want 0", m_valid); end
    checks++; if (det_count !== 16'd3) begin errors++; $display("FAIL cap_det_count: got %0d want 3", det_count); end
    close_frame();
    drain(30, 0);
    checks++; if (!trl_seen || trl_data !== trl(3, 0)) begin errors++; $display("FAIL cap_trailer: seen=%0d got %h want %h", trl_seen, trl_data, trl(3, 0)); end
    wait_idle(ok);
    checks++; if (!ok || det_count !== '0) begin errors++; $display("FAIL cap_clear: idle=%0d det_count=%0d want idle=1 count=0", ok, det_count); end
  endtask

  task automatic test_overflow();
    bit ok;
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      set_det(1, 16'(i), 16'(i + 60));
      step();
    end
    set_det(0, 16'd0, 16'd0);
    checks++; if (det_count !== 16'd4) begin errors++; $display("FAIL ovf_det_count: got %0d want 4", det_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    close_frame();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b want 1", busy); end
    drain(40, 0);
    checks++; if (recs.size() != 4) begin errors++; $display("FAIL ovf_rec_count: got %0d want 4", recs.size()); end
    for (int i = 0; i < recs.size() && i < 4; i++) begin
      checks++; if (recs[i] !== rec(16'(i + 1), 16'(i + 61))) begin errors++; $display("FAIL ovf_rec%0d: got %h want %h", i, recs[i], rec(16'(i + 1), 16'(i + 61))); end
    end
    checks++; if (!trl_seen || trl_data !== trl(4, 2)) begin errors++; $display("FAIL ovf_trailer: seen=%0d got %h want %h", trl_seen, trl_data, trl(4, 2)); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_until_clear: got %b want 1", overflow); end
    step();
    checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovf_after_clear: overflow=%b busy=%b want 0 0", overflow, busy); end
    wait_idle(ok);
  endtask

  task automatic test_frame_end_same_cycle();
    bit ok;
    m_ready = 1'b1;
    set_det(1, 16'd21, 16'd1);
    step();
    set_det(1, 16'd22, 16'd2);
    step();
    set_det(1, 16'd23, 16'd3);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    set_det(1, 16'd24, 16'd4);
    step();
    set_det(0, 16'd0, 16'd0);
    checks++; if (busy !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL fe_flush_drop: busy=%b overflow=%b want 1 1", busy, overflow); end
    drain(30, 0);
    checks++; if (recs.size() != 1 || recs[0] !== rec(16'd23, 16'd3)) begin errors++; $display("FAIL fe_last_rec: n=%0d got %h want %h", recs.size(), (recs.size() > 0) ? recs[0] : '0, rec(16'd23, 16'd3)); end
    checks++; if (!trl_seen || trl_data !== trl(3, 1)) begin errors++; $display("FAIL fe_trailer: seen=%0d got %h want %h", trl_seen, trl_data, trl(3, 1)); end
    wait_idle(ok);
  endtask

  task automatic test_stall_toggle();
    bit ok;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_det(1, 16'(31 + i), 16'(10 + i));
      step();
    end
    set_det(0, 16'd0, 16'd0);
    close_frame();
    drain(60, 1);
    checks++; if (recs.size() != 4) begin errors++; $display("FAIL stall_rec_count: got %0d want 4", recs.size()); end
    for (int i = 0; i < recs.size() && i < 4; i++) begin
      checks++; if (recs[i] !== rec(16'(31 + i), 16'(10 + i))) begin errors++; $display("FAIL stall_rec%0d: got %h want %h", i, recs[i], rec(16'(31 + i), 16'(10 + i))); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d violations want 0", stall_viol); end
    checks++; if (!trl_seen || trl_data !== trl(4, 0)) begin errors++; $display("FAIL stall_trailer: seen=%0d got %h want %h", trl_seen, trl_data, trl(4, 0)); end
    wait_idle(ok);
  endtask

  task automatic test_rst_flush();
    bit ok;
    m_ready = 1'b0;
    set_det(1, 16'd41, 16'd1);
    step();
    set_det(1, 16'd42, 16'd2);
    step();
    set_det(0, 16'd0, 16'd0);
    close_frame();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstf_in_flush: busy=%b want 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || det_count !== '0) begin errors++; $display("FAIL rstf_cleared: m_valid=%b busy=%b det_count=%0d want 0 0 0", m_valid, busy, det_count); end
    step();
    m_ready = 1'b1;
    set_det(1, 16'd43, 16'd5);
    step();
    set_det(0, 16'd0, 16'd0);
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== rec(16'd43, 16'd5)) begin errors++; $display("FAIL rstf_next_rec: v=%b got %h want %h", m_valid, m_data, rec(16'd43, 16'd5)); end
    close_frame();
    drain(30, 0);
    checks++; if (!trl_seen || trl_data !== trl(1, 0)) begin errors++; $display("FAIL rstf_trailer: seen=%0d got %h want %h", trl_seen, trl_data, trl(1, 0)); end
    wait_idle(ok);
  endtask

  task automatic test_zero_skip();
    bit ok;
    int exp_cnt;
`ifdef POLA_YOLO_COLLECT_ZERO_SKIP_EN
    exp_cnt = 1;
`else
    exp_cnt = 3;
`endif
    m_ready = 1'b1;
    set_det(1, 16'd51, 16'd0);
    step();
    set_det(1, 16'd52, 16'd0);
    step();
    set_det(1, 16'd53, 16'd7);
    step();
    set_det(0, 16'd0, 16'd0);
    checks++; if (det_count !== 16'(exp_cnt) || overflow !== 1'b0) begin errors++; $display("FAIL zs_count: det_count=%0d overflow=%b want %0d 0", det_count, overflow, exp_cnt); end
    close_frame();
    drain(30, 0);
    checks++; if (!trl_seen || trl_data !== trl(exp_cnt, 0)) begin errors++; $display("FAIL zs_trailer: seen=%0d got %h want %h", trl_seen, trl_data, trl(exp_cnt, 0)); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zs_idle: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_frame_end_same_cycle();
    test_stall_toggle();
    test_rst_flush();
    test_zero_skip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
